regfile_scoreboard: RTL and testbench

Parametrised successor to the 8x16 single-write register file. Holds NUM_REGS x DATA_W registers with two combinational read ports and one clocked write port. Adds synchronous reset of contents, optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard. The scoreboard lets the issue stage mark a destination as in flight and stall on a write-after-write hazard. It sits between decode/issue and the writeback stage of the CPU datapath.

---
 rtl/regfile_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : NUM_REGS x DATA_W register file with two combinational read
//               ports, one clocked write port, optional write-to-read bypass,
//               optional hardwired-zero register 0 and a per-register pending
//               scoreboard for write-after-write hazard detection at issue.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               read_reg1/2            - read addresses
//               read_data1/2           - read data (combinational)
//               read_ready1/2          - operand valid (not pending or bypassed)
//               write_reg/write_data/reg_write - writeback port
//               issue_reg/issue_valid  - issue destination request
//               issue_stall            - issue refused (WAW hazard)
//               pending_count          - number of pending registers
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_ready1,
    output logic              read_ready2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic              issue_valid,
    output logic              issue_stall,
    output logic [ADDR_W:0]   pending_count
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_count;

    logic                w_write_en;
    logic                w_hazard;
    logic                w_issue_en;
    logic                w_inc;
    logic                w_dec;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // Writes to a hardwired-zero register 0 are dropped entirely.
    assign w_write_en = reg_write && !((ZERO_REG != 0) && (write_reg == '0));

    // A pending destination stops being a hazard if its writeback lands
    // in the same cycle.
    assign w_hazard    = r_pending[issue_reg] && !(reg_write && (write_reg == issue_reg));
    assign issue_stall = issue_valid && w_hazard;

    // Issue to a hardwired-zero register 0 is accepted but tracks nothing.
    assign w_issue_en = issue_valid && !w_hazard &&
                        !((ZERO_REG != 0) && (issue_reg == '0));

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (w_write_en) begin
            w_clr_mask[write_reg] = 1'b1;
        end
        if (w_issue_en) begin
            w_set_mask[issue_reg] = 1'b1;
        end
        // Set is applied after clear: the new producer wins on a same-register collision.
        w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
    end

    // Count moves only on a real bit transition so it always equals the popcount.
    assign w_inc = w_issue_en && !r_pending[issue_reg];
    assign w_dec = w_write_en && r_pending[write_reg] &&
                   !(w_issue_en && (issue_reg == write_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            if (w_write_en) begin
                r_regs[write_reg] <= write_data;
            end
            r_pending <= w_pending_nxt;
            if (w_inc && !w_dec) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign pending_count = r_count;

    // Read ports: zero register, then bypass, then stored state.
    logic [1:0][ADDR_W-1:0] w_raddr;
    logic [1:0][DATA_W-1:0] w_rdata;
    logic [1:0]             w_rready;

    assign w_raddr[0] = read_reg1;
    assign w_raddr[1] = read_reg2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_zero;
        logic w_byp;
        assign w_zero      = (ZERO_REG != 0) && (w_raddr[p] == '0);
        assign w_byp       = (BYPASS != 0) && reg_write && (write_reg == w_raddr[p]);
        assign w_rdata[p]  = w_zero ? '0 : (w_byp ? write_data : r_regs[w_raddr[p]]);
        assign w_rready[p] = w_zero || w_byp || !r_pending[w_raddr[p]];
    end

    assign read_data1  = w_rdata[0];
    assign read_data2  = w_rdata[1];
    assign read_ready1 = w_rready[0];
    assign read_ready2 = w_rready[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed bench for regfile_scoreboard. Three instances share
//               one stimulus: default (bypass, no zero reg), no-bypass, and
//               hardwired-zero register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] read_reg1, read_reg2, write_reg, issue_reg;
    logic [DW-1:0] write_data;
    logic          reg_write, issue_valid;

    logic [DW-1:0] d_rd1, d_rd2, n_rd1, n_rd2, z_rd1, z_rd2;
    logic          d_rdy1, d_rdy2, n_rdy1, n_rdy2, z_rdy1, z_rdy2;
    logic          d_stall, n_stall, z_stall;
    logic [AW:0]   d_cnt, n_cnt, z_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(8), .ZERO_REG(0), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(d_rd1), .read_data2(d_rd2), .read_ready1(d_rdy1), .read_ready2(d_rdy2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .issue_reg(issue_reg), .issue_valid(issue_valid), .issue_stall(d_stall),
        .pending_count(d_cnt));

    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(8), .ZERO_REG(0), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(n_rd1), .read_data2(n_rd2), .read_ready1(n_rdy1), .read_ready2(n_rdy2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .issue_reg(issue_reg), .issue_valid(issue_valid), .issue_stall(n_stall),
        .pending_count(n_cnt));

    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(8), .ZERO_REG(1), .BYPASS(1)) u_zero (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(z_rd1), .read_data2(z_rd2), .read_ready1(z_rdy1), .read_ready2(z_rdy2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .issue_reg(issue_reg), .issue_valid(issue_valid), .issue_stall(z_stall),
        .pending_count(z_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; reg_write = 1'b0; issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reg_write = 1'b0; issue_valid = 1'b0;
        read_reg1 = '0; read_reg2 = '0; write_reg = '0; issue_reg = '0; write_data = '0;
        tick();
        idle();
        #1;
        check("init_count", 32'(d_cnt), 0);
        check("init_ready1", 32'(d_rdy1), 1);
        check("init_stall", 32'(d_stall), 0);
        check("init_data1", 32'(d_rd1), 0);

        // Reset clears stored contents.
        reg_write = 1'b1; write_reg = 3'd3; write_data = 16'h1234;
        tick();
        idle(); read_reg1 = 3'd3;
        #1;
        check("r3_written", 32'(d_rd1), 32'h1234);
        rst = 1'b1;
        tick();
        idle();
        #1;
        check("r3_after_rst", 32'(d_rd1), 0);
        check("r3_ready_after_rst", 32'(d_rdy1), 1);
        check("count_after_rst", 32'(d_cnt), 0);

        // Bypass vs no bypass.
        reg_write = 1'b1; write_reg = 3'd1; write_data = 16'h5678; read_reg1 = 3'd1;
        #1;
        check("bypass_data", 32'(d_rd1), 32'h5678);
        check("bypass_ready", 32'(d_rdy1), 1);
        check("nobyp_old_data", 32'(n_rd1), 0);
        tick();
        idle();
        #1;
        check("nobyp_new_data", 32'(n_rd1), 32'h5678);
        check("byp_new_data", 32'(d_rd1), 32'h5678);

        // Scoreboard issue and writeback.
        issue_valid = 1'b1; issue_reg = 3'd2;
        #1;
        check("issue_r2_stall", 32'(d_stall), 0);
        tick();
        idle(); read_reg2 = 3'd2;
        #1;
        check("r2_pending_ready", 32'(d_rdy2), 0);
        check("r2_pending_count", 32'(d_cnt), 1);
        reg_write = 1'b1; write_reg = 3'd2; write_data = 16'h9999;
        #1;
        check("r2_wb_ready_byp", 32'(d_rdy2), 1);
        check("r2_wb_data_byp", 32'(d_rd2), 32'h9999);
        check("r2_wb_ready_nobyp", 32'(n_rdy2), 0);
        check("r2_wb_data_nobyp", 32'(n_rd2), 0);
        tick();
        idle();
        #1;
        check("r2_cleared_count", 32'(d_cnt), 0);
        check("r2_cleared_ready", 32'(d_rdy2), 1);
        check("r2_cleared_data", 32'(d_rd2), 32'h9999);

        // WAW stall.
        issue_valid = 1'b1; issue_reg = 3'd4;
        tick();
        #1;
        check("waw_stall", 32'(d_stall), 1);
        tick();
        check("waw_count_held", 32'(d_cnt), 1);
        reg_write = 1'b1; write_reg = 3'd4; write_data = 16'h4444;
        #1;
        check("waw_wb_nostall", 32'(d_stall), 0);
        tick();
        idle(); read_reg1 = 3'd4;
        #1;
        check("waw_r4_still_pending", 32'(d_rdy1), 0);
        check("waw_count_same", 32'(d_cnt), 1);
        check("waw_r4_data", 32'(d_rd1), 32'h4444);

        // Fresh state for the zero-register case.
        rst = 1'b1;
        tick();
        idle();

        // Write and issue to r0.
        reg_write = 1'b1; write_reg = 3'd0; write_data = 16'hFFFF;
        issue_valid = 1'b1; issue_reg = 3'd0; read_reg1 = 3'd0;
        #1;
        check("zero_byp_data", 32'(z_rd1), 0);
        check("zero_byp_ready", 32'(z_rdy1), 1);
        check("nonzero_byp_r0", 32'(d_rd1), 32'hFFFF);
        check("zero_issue_stall", 32'(z_stall), 0);
        tick();
        idle();
        #1;
        check("zero_r0_data", 32'(z_rd1), 0);
        check("zero_r0_ready", 32'(z_rdy1), 1);
        check("zero_count", 32'(z_cnt), 0);
        check("nonzero_r0_count", 32'(d_cnt), 1);
        check("nonzero_r0_ready", 32'(d_rdy1), 0);
        check("nonzero_r0_data", 32'(d_rd1), 32'hFFFF);

        // Disabled write has no effect.
        write_reg = 3'd2; write_data = 16'h9999; read_reg2 = 3'd2;
        tick();
        check("no_we_r2_zero", 32'(z_rd2), 0);
        check("no_we_r2_dut", 32'(d_rd2), 0);

        // Reset in the middle of outstanding work.
        issue_valid = 1'b1; issue_reg = 3'd1;
        tick();
        issue_reg = 3'd3;
        tick();
        issue_reg = 3'd6;
        tick();
        idle();
        #1;
        check("three_pending_zero", 32'(z_cnt), 3);
        check("four_pending_dut", 32'(d_cnt), 4);
        rst = 1'b1; issue_valid = 1'b1; issue_reg = 3'd5;
        tick();
        idle(); read_reg1 = 3'd5; read_reg2 = 3'd3;
        #1;
        check("rst_mid_count", 32'(d_cnt), 0);
        check("rst_mid_count_zero", 32'(z_cnt), 0);
        check("rst_mid_r5_ready", 32'(d_rdy1), 1);
        check("rst_mid_r3_ready", 32'(d_rdy2), 1);
        issue_valid = 1'b1; issue_reg = 3'd5;
        #1;
        check("rst_mid_r5_nostall", 32'(d_stall), 0);
        tick();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
